// File: rtl/snoop_resp_ctrl_lv1_pkg.sv
// Shared types for the L1 snoop-response controller: MESI encoding,
// FSM states, decoded bus command and the command priority decode.
`ifndef ASSOC_LV1
`define ASSOC_LV1 4
`endif
`ifndef ASSOC_WID_LV1
`define ASSOC_WID_LV1 2
`endif
`ifndef MESI_WID_LV1
`define MESI_WID_LV1 2
`endif

package lv1_snoop_pkg;

   localparam int LV1_ASSOC     = `ASSOC_LV1;
   localparam int LV1_ASSOC_WID = `ASSOC_WID_LV1;
   localparam int LV1_MESI_WID  = `MESI_WID_LV1;

   typedef enum logic [1:0] {
      MESI_I = 2'd0,
      MESI_S = 2'd1,
      MESI_E = 2'd2,
      MESI_M = 2'd3
   } mesi_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_FLUSH,
      ST_UPDATE,
      ST_DONE
   } snoop_state_e;

   typedef enum logic [1:0] {
      CMD_NONE,
      CMD_RD,
      CMD_RDX,
      CMD_INV
   } cmd_e;

   // rdx wins over rd, rd over invalidate when several bits are set
   function automatic cmd_e cmd_decode(input logic rd, input logic rdx, input logic inv);
      if (rdx) return CMD_RDX;
      if (rd)  return CMD_RD;
      if (inv) return CMD_INV;
      return CMD_NONE;
   endfunction

endpackage

// File: rtl/snoop_resp_ctrl_lv1_if.sv
// Snoop bus + L1 MESI array port bundle between the system bus side
// (master) and the per-core snoop-response controller (slave).
interface snoop_resp_ctrl_lv1_if #(
   parameter int ASSOC     = 4,
   parameter int ASSOC_WID = 2,
   parameter int MESI_WID  = 2
);
   logic                      snoop_req;
   logic                      bus_rd;
   logic                      bus_rdx;
   logic                      invalidate;
   logic [ASSOC-1:0]          access_blk_snoop;
   logic [ASSOC*MESI_WID-1:0] cache_snoop_mesi;
   logic                      flush_ack;

   logic                      snoop_busy;
   logic                      snoop_done;
   logic                      shared;
   logic                      flush_req;
   logic                      mesi_wr_en;
   logic [ASSOC_WID-1:0]      mesi_wr_way;
   logic [MESI_WID-1:0]       mesi_wr_state;
   logic                      proto_err;

   modport master (
      output snoop_req, bus_rd, bus_rdx, invalidate, access_blk_snoop,
             cache_snoop_mesi, flush_ack,
      input  snoop_busy, snoop_done, shared, flush_req, mesi_wr_en,
             mesi_wr_way, mesi_wr_state, proto_err
   );

   modport slave (
      input  snoop_req, bus_rd, bus_rdx, invalidate, access_blk_snoop,
             cache_snoop_mesi, flush_ack,
      output snoop_busy, snoop_done, shared, flush_req, mesi_wr_en,
             mesi_wr_way, mesi_wr_state, proto_err
   );
endinterface

// File: rtl/snoop_resp_ctrl_lv1_mesi_next.sv
// MESI transition table for a snooped command: new state, whether a dirty
// line must be flushed first, and whether the transition is illegal.
module snoop_mesi_next_lv1
   import lv1_snoop_pkg::*;
(
   input  cmd_e  cmd_i,
   input  mesi_e cur_i,
   output mesi_e nxt_o,
   output logic  needs_flush_o,
   output logic  err_o
);

   always_comb begin
      nxt_o         = cur_i;
      needs_flush_o = 1'b0;
      err_o         = 1'b0;
      case (cmd_i)
         CMD_RD: begin
            nxt_o         = MESI_S;
            needs_flush_o = (cur_i == MESI_M);
         end
         CMD_RDX: begin
            nxt_o         = MESI_I;
            needs_flush_o = (cur_i == MESI_M);
         end
         CMD_INV: begin
            // an owner should never see a plain invalidate from another core
            nxt_o = MESI_I;
            err_o = (cur_i == MESI_E) || (cur_i == MESI_M);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/snoop_resp_ctrl_lv1.sv
// Per-core L1 snoop-side controller: qualifies a snooped command against
// the tag hit, flushes Modified lines, writes back MESI state, signals done.
module snoop_resp_ctrl_lv1
   import lv1_snoop_pkg::*;
#(
   parameter int ASSOC     = LV1_ASSOC,
   parameter int ASSOC_WID = LV1_ASSOC_WID,
   parameter int MESI_WID  = LV1_MESI_WID
) (
   input  logic                 clk,
   input  logic                 rst,
   snoop_resp_ctrl_lv1_if.slave snp
);

   snoop_state_e         state_q, state_d;
   cmd_e                 cmd_q, cmd_d;
   logic [ASSOC_WID-1:0] way_q, way_d;
   mesi_e                cur_q, cur_d;
   logic                 hit_q, hit_d;
   logic                 proto_err_q, proto_err_d;

   logic [ASSOC_WID-1:0] hit_way;
   logic [MESI_WID-1:0]  hit_mesi;
   cmd_e                 cmd_in;
   logic                 hit_in, multi_hot, cmd_err;
   mesi_e                nxt;
   logic                 needs_flush, tr_err;

   // lowest-index way wins on a multi-hot vector
   always_comb begin
      hit_way = '0;
      for (int i = ASSOC - 1; i >= 0; i--)
         if (snp.access_blk_snoop[i]) hit_way = ASSOC_WID'(i);
   end

   assign hit_mesi  = snp.cache_snoop_mesi[int'(hit_way) * MESI_WID +: MESI_WID];
   assign cmd_in    = cmd_decode(snp.bus_rd, snp.bus_rdx, snp.invalidate);
   assign cmd_err   = $countones({snp.bus_rd, snp.bus_rdx, snp.invalidate}) != 1;
   assign multi_hot = (snp.access_blk_snoop & (snp.access_blk_snoop - ASSOC'(1))) != '0;
   // a tag match on an Invalid way, or no command at all, is a miss
   assign hit_in    = (snp.access_blk_snoop != '0) && (mesi_e'(hit_mesi) != MESI_I) &&
                      (cmd_in != CMD_NONE);

   snoop_mesi_next_lv1 u_mesi_next (
      .cmd_i         (cmd_q),
      .cur_i         (cur_q),
      .nxt_o         (nxt),
      .needs_flush_o (needs_flush),
      .err_o         (tr_err)
   );

   always_comb begin
      state_d           = state_q;
      cmd_d             = cmd_q;
      way_d             = way_q;
      cur_d             = cur_q;
      hit_d             = hit_q;
      proto_err_d       = proto_err_q;
      snp.snoop_done    = 1'b0;
      snp.flush_req     = 1'b0;
      snp.mesi_wr_en    = 1'b0;
      snp.mesi_wr_way   = '0;
      snp.mesi_wr_state = '0;
      case (state_q)
         ST_IDLE: begin
            if (snp.snoop_req) begin
               cmd_d       = cmd_in;
               way_d       = hit_way;
               cur_d       = mesi_e'(hit_mesi);
               hit_d       = hit_in;
               proto_err_d = proto_err_q | cmd_err | multi_hot;
               state_d     = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            if (!hit_q)           state_d = ST_DONE;
            else if (needs_flush) state_d = ST_FLUSH;
            else                  state_d = ST_UPDATE;
         end
         ST_FLUSH: begin
            snp.flush_req = 1'b1;
            if (snp.flush_ack) state_d = ST_UPDATE;
         end
         ST_UPDATE: begin
            snp.mesi_wr_en    = 1'b1;
            snp.mesi_wr_way   = way_q;
            snp.mesi_wr_state = MESI_WID'(nxt);
            proto_err_d       = proto_err_q | tr_err;
            state_d           = ST_DONE;
         end
         ST_DONE: begin
            snp.snoop_done = 1'b1;
            state_d        = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign snp.snoop_busy = (state_q != ST_IDLE);
   assign snp.shared     = (state_q != ST_IDLE) && hit_q;
   assign snp.proto_err  = proto_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cmd_q       <= CMD_NONE;
         way_q       <= '0;
         cur_q       <= MESI_I;
         hit_q       <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         way_q       <= way_d;
         cur_q       <= cur_d;
         hit_q       <= hit_d;
         proto_err_q <= proto_err_d;
      end
   end

endmodule
